// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {instruction, address} pairs
// with valid/ready on both sides, flush for redirects and a NOP bubble when empty.
`timescale 1ns/1ps
module inst_queue #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_inst,
  input  logic [XLEN-1:0]          in_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_inst,
  output logic [XLEN-1:0]          out_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              push_s, pop_s;
  logic [2*XLEN-1:0] head_s;

  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != CNT_ZERO);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign head_s    = mem_q[rd_ptr_q];
  assign out_inst  = out_valid ? head_s[2*XLEN-1:XLEN] : NOP_INST[XLEN-1:0];
  assign out_addr  = out_valid ? head_s[XLEN-1:0] : {XLEN{1'b0}};
  assign count     = count_q;

  // Next-state for pointers and occupancy; flush overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are left stale across reset and flush.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_q[wr_ptr_q] <= {in_inst, in_addr};
    end
  end

endmodule
